// File: rtl/core_bpu_ras.sv
// rtl/core_bpu_ras.sv - return address stack with speculative push/pop and misprediction recovery
module core_bpu_ras #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid_i,
  input  logic [1:0]       f_type_i,
  input  logic [31:0]      f_pc_i,
  output logic [31:0]      top_o,
  output logic             top_valid_o,
  output logic [PTR_W-1:0] ptr_o,
  input  logic             c_valid_i,
  input  logic             c_miss_i,
  input  logic [1:0]       c_type_i,
  input  logic [PTR_W-1:0] c_ptr_i,
  input  logic [31:0]      c_pc_i
);

  localparam logic [1:0] TYPE_CALL = 2'd1;
  localparam logic [1:0] TYPE_RET  = 2'd2;

  logic [31:0]      stack_q [DEPTH];
  logic [31:0]      stack_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             recover;

  assign recover = c_valid_i && c_miss_i;
  // Pointer arithmetic wraps naturally at PTR_W bits, giving modulo-DEPTH behaviour.
  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);

  always_comb begin
    stack_d = stack_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (recover) begin
      // The jump unit's checkpoint is authoritative; any fetch update this cycle is dropped.
      ptr_d = c_ptr_i;
      if (c_type_i == TYPE_CALL) begin
        stack_d[c_ptr_i] = c_pc_i + 32'd4;
        valid_d[c_ptr_i] = 1'b1;
      end
    end else if (f_valid_i) begin
      if (f_type_i == TYPE_CALL) begin
        ptr_d            = ptr_inc;
        stack_d[ptr_inc] = f_pc_i + 32'd4;
        valid_d[ptr_inc] = 1'b1;
      end else if (f_type_i == TYPE_RET) begin
        ptr_d = ptr_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_q <= '{default: '0};
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      stack_q <= stack_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign top_o       = stack_q[ptr_q];
  assign top_valid_o = valid_q[ptr_q];
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_core_bpu_ras.sv
// tb/tb_core_bpu_ras.sv - directed self-checking bench for core_bpu_ras
module tb_core_bpu_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid_i = 1'b0;
  logic [1:0]  f_type_i = 2'd0;
  logic [31:0] f_pc_i = '0;
  logic [31:0] top_o;
  logic        top_valid_o;
  logic [2:0]  ptr_o;
  logic        c_valid_i = 1'b0;
  logic        c_miss_i = 1'b0;
  logic [1:0]  c_type_i = 2'd0;
  logic [2:0]  c_ptr_i = '0;
  logic [31:0] c_pc_i = '0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pop [9];

  core_bpu_ras #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .f_valid_i(f_valid_i), .f_type_i(f_type_i), .f_pc_i(f_pc_i),
    .top_o(top_o), .top_valid_o(top_valid_o), .ptr_o(ptr_o),
    .c_valid_i(c_valid_i), .c_miss_i(c_miss_i), .c_type_i(c_type_i),
    .c_ptr_i(c_ptr_i), .c_pc_i(c_pc_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] p, input logic [31:0] t, input logic v);
    chk({tag, ".ptr"}, 32'(ptr_o), 32'(p));
    chk({tag, ".top"}, top_o, t);
    chk({tag, ".valid"}, 32'(top_valid_o), 32'(v));
  endtask

  task automatic idle();
    f_valid_i = 1'b0; f_type_i = 2'd0; f_pc_i = '0;
    c_valid_i = 1'b0; c_miss_i = 1'b0; c_type_i = 2'd0; c_ptr_i = '0; c_pc_i = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [1:0] ty, input logic [31:0] pc);
    f_valid_i = 1'b1; f_type_i = ty; f_pc_i = pc;
    cycle();
    idle();
  endtask

  task automatic correct(input logic miss, input logic [1:0] ty, input logic [2:0] p, input logic [31:0] pc);
    c_valid_i = 1'b1; c_miss_i = miss; c_type_i = ty; c_ptr_i = p; c_pc_i = pc;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_pop = '{32'h904, 32'h804, 32'h704, 32'h604, 32'h504, 32'h404, 32'h304, 32'h204, 32'h904};
    idle();
    #2;
    chk_state("reset", 3'd0, 32'h0, 1'b0);
    do_reset();

    fetch(2'd1, 32'h1C000000);
    chk_state("push1", 3'd1, 32'h1C000004, 1'b1);
    fetch(2'd2, 32'h0);
    chk_state("pop1", 3'd0, 32'h0, 1'b0);

    do_reset();
    fetch(2'd2, 32'h0);
    chk_state("pop_underflow", 3'd7, 32'h0, 1'b0);

    do_reset();
    for (int i = 1; i <= 9; i++) fetch(2'd1, 32'(i) * 32'h100);
    chk_state("push9", 3'd1, 32'h904, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("pop9[%0d]", i), top_o, exp_pop[i]);
      fetch(2'd2, 32'h0);
    end
    chk("pop9.ptr_end", 32'(ptr_o), 32'd0);
    chk("pop9.entry0", top_o, 32'h804);

    do_reset();
    fetch(2'd1, 32'hA00);
    fetch(2'd1, 32'hB00);
    chk_state("pushB", 3'd2, 32'hB04, 1'b1);
    f_valid_i = 1'b1; f_type_i = 2'd1; f_pc_i = 32'hC00;
    correct(1'b1, 2'd1, 3'd1, 32'hD00);
    chk_state("recover_prio", 3'd1, 32'hD04, 1'b1);
    correct(1'b1, 2'd3, 3'd2, 32'h0);
    chk_state("stack2_kept", 3'd2, 32'hB04, 1'b1);

    correct(1'b1, 2'd2, 3'd3, 32'hEEE0);
    chk_state("recover_ret", 3'd3, 32'h0, 1'b0);
    correct(1'b1, 2'd0, 3'd1, 32'hEEE0);
    chk_state("recover_none", 3'd1, 32'hD04, 1'b1);
    correct(1'b1, 2'd0, 3'd3, 32'h0);
    correct(1'b0, 2'd1, 3'd5, 32'h1234);
    chk_state("nomiss_ignored", 3'd3, 32'h0, 1'b0);
    f_valid_i = 1'b1; f_type_i = 2'd1; f_pc_i = 32'hFFFFFFFC;
    correct(1'b0, 2'd1, 3'd5, 32'h1234);
    chk_state("nomiss_push_wrap", 3'd4, 32'h0, 1'b1);

    fetch(2'd3, 32'h5000);
    chk_state("type3_nop", 3'd4, 32'h0, 1'b1);
    f_valid_i = 1'b0; f_type_i = 2'd1; f_pc_i = 32'h6000;
    cycle();
    idle();
    chk_state("fvalid_low_nop", 3'd4, 32'h0, 1'b1);
    fetch(2'd0, 32'h7000);
    chk_state("type0_nop", 3'd4, 32'h0, 1'b1);

    // Async reset between edges, then held across an edge with a push pending.
    f_valid_i = 1'b1; f_type_i = 2'd1; f_pc_i = 32'h8000;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_state("async_rst", 3'd0, 32'h0, 1'b0);
    cycle();
    chk_state("rst_held", 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    idle();
    chk_state("first_after_rst", 3'd1, 32'h8004, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
